car_frame_sequencer: RTL and testbench

//   Per-frame controller upstream of the car-erase and car-draw stages.
//   On each frame tick with a direction key held, it does three things in order:

---
 rtl/car_frame_sequencer.sv | 154 +++++++++++++++
 tb/tb_car_frame_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/car_frame_sequencer.sv
// Per-frame erase/move/draw sequencer for the car sprite.
// Define CAR_WRAP_EN for toroidal wrap at the screen edges; the default build clamps instead.
module car_frame_sequencer #(
    parameter int unsigned TICK_CYCLES = 833333,
    parameter int unsigned STEP        = 1,
    parameter int unsigned CAR_SIZE    = 20,
    parameter int unsigned SCREEN_W    = 160,
    parameter int unsigned SCREEN_H    = 120,
    parameter int unsigned START_X     = 70,
    parameter int unsigned START_Y     = 50
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       erase_done,
    input  logic       draw_done,
    output logic       erase_en,
    output logic       draw_en,
    output logic [7:0] car_x,
    output logic [6:0] car_y,
    output logic       busy,
    output logic       overrun
);

    localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CntW-1:0] TickLast = CntW'(TICK_CYCLES - 1);
    localparam logic signed [8:0] MaxX  = 9'(SCREEN_W - CAR_SIZE);
    localparam logic signed [8:0] MaxY  = 9'(SCREEN_H - CAR_SIZE);
    localparam logic signed [8:0] StepS = 9'(STEP);

    typedef enum logic [2:0] {
        StIdle,
        StWaitTick,
        StErase,
        StMove,
        StDraw
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      keys_q, keys_d;  // {left, right, up, down}
    logic [7:0]      car_x_q, car_x_d;
    logic [6:0]      car_y_q, car_y_d;
    logic            erase_en_q, erase_en_d;
    logic            draw_en_q, draw_en_d;
    logic            busy_q, busy_d;
    logic            overrun_q, overrun_d;
    logic            tick;
    logic            any_key;

    // One axis update: opposing keys cancel, then clamp or wrap into 0..max_pos.
    function automatic logic signed [8:0] next_pos(input logic signed [8:0] pos,
                                                   input logic inc, input logic dec,
                                                   input logic signed [8:0] max_pos);
        logic signed [8:0] sum;
        sum = pos;
        if (inc && !dec) begin
            sum = pos + StepS;
        end else if (dec && !inc) begin
            sum = pos - StepS;
        end
`ifdef CAR_WRAP_EN
        if (sum > max_pos) begin
            sum = sum - (max_pos + 9'sd1);
        end else if (sum < 9'sd0) begin
            sum = sum + (max_pos + 9'sd1);
        end
`else
        if (sum > max_pos) begin
            sum = max_pos;
        end else if (sum < 9'sd0) begin
            sum = 9'sd0;
        end
`endif
        return sum;
    endfunction

    assign tick    = (cnt_q == TickLast);
    assign cnt_d   = tick ? '0 : cnt_q + 1'b1;
    assign any_key = key_left | key_right | key_up | key_down;

    always_comb begin
        state_d   = state_q;
        keys_d    = keys_q;
        car_x_d   = car_x_q;
        car_y_d   = car_y_q;
        // busy_q mirrors the current state, so this flags a tick dropped mid-sequence.
        overrun_d = overrun_q | (tick & busy_q);
        unique case (state_q)
            StIdle: begin
                if (go) state_d = StDraw;
            end
            StWaitTick: begin
                if (!go) begin
                    state_d = StIdle;
                end else if (tick && any_key) begin
                    keys_d  = {key_left, key_right, key_up, key_down};
                    state_d = StErase;
                end
            end
            StErase: begin
                if (erase_done) state_d = StMove;
            end
            StMove: begin
                car_x_d = 8'(next_pos($signed({1'b0, car_x_q}), keys_q[2], keys_q[3], MaxX));
                car_y_d = 7'(next_pos($signed({2'b0, car_y_q}), keys_q[0], keys_q[1], MaxY));
                state_d = StDraw;
            end
            StDraw: begin
                if (draw_done) state_d = StWaitTick;
            end
            default: state_d = StIdle;
        endcase
        erase_en_d = (state_d == StErase);
        draw_en_d  = (state_d == StDraw);
        busy_d     = (state_d == StErase) || (state_d == StMove) || (state_d == StDraw);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            keys_q     <= '0;
            car_x_q    <= 8'(START_X);
            car_y_q    <= 7'(START_Y);
            erase_en_q <= 1'b0;
            draw_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            keys_q     <= keys_d;
            car_x_q    <= car_x_d;
            car_y_q    <= car_y_d;
            erase_en_q <= erase_en_d;
            draw_en_q  <= draw_en_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign erase_en = erase_en_q;
    assign draw_en  = draw_en_q;
    assign car_x    = car_x_q;
    assign car_y    = car_y_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_car_frame_sequencer.sv
// Scoreboard bench for car_frame_sequencer with a 16-cycle frame tick.
// Expected erase/draw positions are queued by the stimulus and checked by a monitor.
module tb_car_frame_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       go = 1'b0;
    logic       key_left = 1'b0, key_right = 1'b0, key_up = 1'b0, key_down = 1'b0;
    logic       erase_done = 1'b0, draw_done = 1'b0;
    logic       erase_en, draw_en, busy, overrun;
    logic [7:0] car_x;
    logic [6:0] car_y;

    typedef struct {
        bit is_draw;
        int x;
        int y;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   ex = 70, ey = 50;
    logic prev_e = 1'b0, prev_d = 1'b0;
    int   cur_x = 70, cur_y = 50;

    car_frame_sequencer #(
        .TICK_CYCLES(16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .go         (go),
        .key_left   (key_left),
        .key_right  (key_right),
        .key_up     (key_up),
        .key_down   (key_down),
        .erase_done (erase_done),
        .draw_done  (draw_done),
        .erase_en   (erase_en),
        .draw_en    (draw_en),
        .car_x      (car_x),
        .car_y      (car_y),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // Monitor: every rising enable consumes one expected record; position must hold while enabled.
    always @(negedge clk) begin
        if ((erase_en && !prev_e) || (draw_en && !prev_d)) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_enable: got erase_en=%0b draw_en=%0b car=(%0d,%0d) required no enable",
                         erase_en, draw_en, car_x, car_y);
            end else begin
                exp_t e;
                e = sb.pop_front();
                cur_x = e.x;
                cur_y = e.y;
                if (e.is_draw != draw_en || car_x != e.x || car_y != e.y) begin
                    miscompares++;
                    $display("FAIL enable_pos: got draw=%0b car=(%0d,%0d) required draw=%0b car=(%0d,%0d)",
                             draw_en, car_x, car_y, e.is_draw, e.x, e.y);
                end
            end
        end else if (erase_en || draw_en) begin
            vectors++;
            if (car_x != cur_x || car_y != cur_y) begin
                miscompares++;
                $display("FAIL pos_stable: got car=(%0d,%0d) required (%0d,%0d)",
                         car_x, car_y, cur_x, cur_y);
            end
        end
        prev_e = erase_en;
        prev_d = draw_en;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic wait_en(input bit want_draw, input string name);
        for (int i = 0; i < 64; i++) begin
            step();
            if (want_draw ? draw_en : erase_en) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL %s: got no enable in 64 cycles required enable", name);
    endtask

    task automatic finish_draw();
        step();
        draw_done = 1'b1;
        step();
        draw_done = 1'b0;
        chk("draw_en_drop", int'(draw_en), 0);
        chk("idle_after_draw", int'(busy), 0);
    endtask

    // One full tick sequence with the given keys; hold delays erase_done.
    task automatic do_move(input bit l, input bit r, input bit u, input bit d,
                           input int nx, input int ny, input int hold);
        sb.push_back('{1'b0, ex, ey});
        sb.push_back('{1'b1, nx, ny});
        {key_left, key_right, key_up, key_down} = {l, r, u, d};
        wait_en(1'b0, "erase_start");
        {key_left, key_right, key_up, key_down} = 4'b0000;
        repeat (hold) step();
        if (hold > 16) begin
            chk("overrun_set", int'(overrun), 1);
            chk("erase_held", int'(erase_en), 1);
        end
        erase_done = 1'b1;
        step();
        erase_done = 1'b0;
        chk("move_gap", int'(erase_en | draw_en), 0);
        chk("move_busy", int'(busy), 1);
        step();
        chk("draw_after_move", int'(draw_en), 1);
        finish_draw();
        ex = nx;
        ey = ny;
    endtask

    initial begin
        // 1: reset state, then initial paint
        step();
        step();
        chk("rst_erase_en", int'(erase_en), 0);
        chk("rst_draw_en", int'(draw_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_x", int'(car_x), 70);
        chk("rst_y", int'(car_y), 50);
        sb.push_back('{1'b1, 70, 50});
        resetn = 1'b1;
        go = 1'b1;
        wait_en(1'b1, "initial_draw");
        chk("draw_busy", int'(busy), 1);
        finish_draw();

        // 2: single step right
        do_move(1'b0, 1'b1, 1'b0, 1'b0, 71, 50, 0);

        // 4: opposing keys cancel; no key means no sequence
        do_move(1'b1, 1'b1, 1'b0, 1'b0, 71, 50, 1);
        repeat (40) step();
        chk("nokey_busy", int'(busy), 0);
        chk("nokey_en", int'(erase_en | draw_en), 0);

        // 3: walk to the bottom-right corner, then push past it
        for (int i = 1; i <= 50; i++) do_move(1'b0, 1'b1, 1'b0, 1'b1, 71 + i, 50 + i, 0);
        for (int i = 1; i <= 19; i++) do_move(1'b0, 1'b1, 1'b0, 1'b0, 121 + i, 100, 0);
`ifdef CAR_WRAP_EN
        do_move(1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0);
`else
        do_move(1'b0, 1'b1, 1'b0, 1'b1, 140, 100, 0);
`endif
        chk("overrun_clear", int'(overrun), 0);

        // 5: erase_done withheld across a tick
`ifdef CAR_WRAP_EN
        do_move(1'b1, 1'b0, 1'b0, 1'b0, 140, 0, 20);
`else
        do_move(1'b1, 1'b0, 1'b0, 1'b0, 139, 100, 20);
`endif
        chk("overrun_sticky", int'(overrun), 1);

        // 6: reset while drawing
        sb.push_back('{1'b0, ex, ey});
`ifdef CAR_WRAP_EN
        sb.push_back('{1'b1, 140, 100});
`else
        sb.push_back('{1'b1, 139, 99});
`endif
        key_up = 1'b1;
        wait_en(1'b0, "erase_before_reset");
        key_up = 1'b0;
        erase_done = 1'b1;
        step();
        erase_done = 1'b0;
        wait_en(1'b1, "draw_before_reset");
        resetn = 1'b0;
        go = 1'b0;
        step();
        chk("rstdraw_draw_en", int'(draw_en), 0);
        chk("rstdraw_busy", int'(busy), 0);
        chk("rstdraw_x", int'(car_x), 70);
        chk("rstdraw_y", int'(car_y), 50);
        chk("rstdraw_overrun", int'(overrun), 0);
        resetn = 1'b1;
        repeat (20) step();
        chk("post_reset_idle", int'(busy | erase_en | draw_en), 0);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
